// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (5..8 data bits, optional even/odd parity)
// with a valid/read handshake, per-byte error flags and a sticky overrun flag.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic       uart_clk_i,
    input  logic       uart_rst_i,
    input  logic       rx_clk_en_i,
    input  logic       rx_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       rx_rd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_overrun_o,
    output logic       rx_busy_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    state_e     state_q;
    logic       sync_q, rx_s_q, armed_q, par_en_q, par_odd_q, par_err_q;
    logic [3:0] tick_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q, shift_d, shift_al;
    logic       commit;
    // Bits enter at the MSB, so a short frame ends up left-aligned in shift_q.
    assign shift_d   = {rx_s_q, shift_q[7:1]};
    assign shift_al  = shift_q >> (8 - DATA_BITS);
    assign commit    = state_q == STOP && rx_clk_en_i && tick_q == 4'd15;
    assign rx_busy_o = state_q != IDLE;
    always_ff @(posedge uart_clk_i) begin
        if (uart_rst_i) begin
            state_q         <= IDLE;
            sync_q          <= 1'b1;
            rx_s_q          <= 1'b1;
            armed_q         <= 1'b0;
            par_en_q        <= 1'b0;
            par_odd_q       <= 1'b0;
            par_err_q       <= 1'b0;
            tick_q          <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            rx_data_o       <= '0;
            rx_valid_o      <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            sync_q <= rx_i;
            rx_s_q <= sync_q;
            if (commit) begin
                rx_data_o       <= shift_al;
                rx_parity_err_o <= par_en_q & par_err_q;
                rx_frame_err_o  <= ~rx_s_q;
                rx_valid_o      <= 1'b1;
                rx_overrun_o    <= rx_rd_i ? 1'b0 : (rx_valid_o | rx_overrun_o);
            end else if (rx_rd_i && rx_valid_o) begin
                rx_valid_o   <= 1'b0;
                rx_overrun_o <= 1'b0;
            end
            if (rx_clk_en_i) begin
                case (state_q)
                    IDLE:
                        if (rx_s_q) armed_q <= 1'b1;
                        else if (armed_q) begin
                            state_q   <= START;
                            tick_q    <= '0;
                            armed_q   <= 1'b0;
                            par_en_q  <= parity_en_i;
                            par_odd_q <= parity_odd_i;
                            par_err_q <= 1'b0;
                        end
                    START:
                        if (tick_q == 4'd7) begin
                            state_q <= rx_s_q ? IDLE : DATA;
                            tick_q  <= '0;
                            bit_q   <= '0;
                        end else tick_q <= tick_q + 4'd1;
                    DATA:
                        if (tick_q == 4'd15) begin
                            shift_q <= shift_d;
                            bit_q   <= bit_q + 3'd1;
                            tick_q  <= '0;
                            if (bit_q == 3'(DATA_BITS - 1)) state_q <= par_en_q ? PARITY : STOP;
                        end else tick_q <= tick_q + 4'd1;
                    PARITY:
                        if (tick_q == 4'd15) begin
                            par_err_q <= rx_s_q ^ (^shift_al) ^ par_odd_q;
                            state_q   <= STOP;
                            tick_q    <= '0;
                        end else tick_q <= tick_q + 4'd1;
                    STOP:
                        // Disarm so a held-low break is delivered only once.
                        if (tick_q == 4'd15) begin
                            state_q <= IDLE;
                            armed_q <= 1'b0;
                            tick_q  <= '0;
                        end else tick_q <= tick_q + 4'd1;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx, one 8-bit and one 5-bit instance,
// tick every 4 clocks so one bit lasts 64 clocks.
module tb_uart_rx;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, rx = 1'b1, rx5 = 1'b1;
    logic       pen = 1'b0, podd = 1'b0, rd = 1'b0;
    logic [7:0] data, data5;
    logic       valid, perr, ferr, ovr, busy, valid5, perr5, ferr5, ovr5, busy5;
    int         checks = 0, failures = 0;
    int         cn, cal, rises, seen;
    logic       prev;

    always #5 clk = ~clk;

    uart_rx dut (
        .uart_clk_i(clk), .uart_rst_i(rst), .rx_clk_en_i(en), .rx_i(rx),
        .parity_en_i(pen), .parity_odd_i(podd), .rx_rd_i(rd),
        .rx_data_o(data), .rx_valid_o(valid), .rx_parity_err_o(perr),
        .rx_frame_err_o(ferr), .rx_overrun_o(ovr), .rx_busy_o(busy)
    );

    uart_rx #(.DATA_BITS(5)) dut5 (
        .uart_clk_i(clk), .uart_rst_i(rst), .rx_clk_en_i(en), .rx_i(rx5),
        .parity_en_i(pen), .parity_odd_i(podd), .rx_rd_i(rd),
        .rx_data_o(data5), .rx_valid_o(valid5), .rx_parity_err_o(perr5),
        .rx_frame_err_o(ferr5), .rx_overrun_o(ovr5), .rx_busy_o(busy5)
    );

    initial forever begin
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Sends one frame starting just after a tick, so commit timing is repeatable.
    // rd is raised for the edge following negedge number rd_at; cn returns the
    // first negedge at which the selected DUT shows a new byte.
    task automatic send(input logic [7:0] d, input int nb, input logic pe, input logic pb,
                        input logic sb, input int rd_at, input logic sel, output int cnt);
        logic [11:0] fr;
        logic [7:0]  d0;
        int          len, n;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < nb; i++) fr[1 + i] = d[i];
        len = 1 + nb;
        if (pe) begin
            fr[len] = pb;
            len++;
        end
        fr[len] = sb;
        len++;
        d0 = sel ? data5 : data;
        cnt = -1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            if (en) break;
        end
        @(negedge clk);
        for (int b = 0; b < len; b++) begin
            if (sel) rx5 = fr[b]; else rx = fr[b];
            repeat (64) begin
                @(negedge clk);
                n++;
                rd = (n == rd_at);
                if (cnt < 0 && (sel ? data5 : data) != d0) cnt = n;
            end
        end
        rd = 1'b0;
        rx = 1'b1;
        rx5 = 1'b1;
        idle(64);
    endtask

    initial begin
        idle(5);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_busy", busy, 0);
        idle(64);

        send(8'hA5, 8, 0, 0, 1, -1, 0, cn);
        chk("a5_data", data, 8'hA5);
        chk("a5_valid", valid, 1);
        chk("a5_perr", perr, 0);
        chk("a5_ferr", ferr, 0);
        chk("a5_busy", busy, 0);
        pulse_rd();
        chk("rd_valid", valid, 0);
        chk("rd_data_hold", data, 8'hA5);

        pen = 1'b1;
        podd = 1'b0;
        send(8'h03, 8, 1, 0, 1, -1, 0, cn);
        chk("even_perr", perr, 0);
        chk("even_data", data, 8'h03);
        pulse_rd();
        podd = 1'b1;
        send(8'h03, 8, 1, 0, 1, -1, 0, cn);
        chk("odd_perr", perr, 1);
        chk("odd_data", data, 8'h03);
        pulse_rd();
        pen = 1'b0;
        podd = 1'b0;

        send(8'h55, 8, 0, 0, 0, -1, 0, cn);
        chk("fe_ferr", ferr, 1);
        chk("fe_data", data, 8'h55);
        chk("fe_perr", perr, 0);
        pulse_rd();

        // Break: 40 bit times low, then idle high.
        rises = 0;
        prev = valid;
        rx = 1'b0;
        repeat (40 * 64) begin
            @(negedge clk);
            if (valid && !prev) rises++;
            prev = valid;
        end
        rx = 1'b1;
        repeat (128) begin
            @(negedge clk);
            if (valid && !prev) rises++;
            prev = valid;
        end
        chk("brk_commits", rises, 1);
        chk("brk_data", data, 8'h00);
        chk("brk_ferr", ferr, 1);
        chk("brk_ovr", ovr, 0);
        pulse_rd();
        send(8'h5A, 8, 0, 0, 1, -1, 0, cn);
        chk("post_brk_data", data, 8'h5A);
        chk("post_brk_ferr", ferr, 0);
        pulse_rd();

        // Glitch: 3 ticks low on an idle line.
        seen = 0;
        rx = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        rx = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        chk("gl_detected", seen, 1);
        chk("gl_busy", busy, 0);
        chk("gl_valid", valid, 0);
        idle(64);

        send(8'h11, 8, 0, 0, 1, -1, 0, cn);
        chk("ov1_ovr", ovr, 0);
        send(8'h22, 8, 0, 0, 1, -1, 0, cal);
        chk("ov_data", data, 8'h22);
        chk("ov_ovr", ovr, 1);
        chk("ov_valid", valid, 1);
        send(8'h33, 8, 0, 0, 1, cal - 1, 0, cn);
        chk("sim_align", cn, cal);
        chk("sim_valid", valid, 1);
        chk("sim_ovr", ovr, 0);
        chk("sim_data", data, 8'h33);

        // Reset in the middle of data bit 4, with an unread byte pending.
        rx = 1'b0;
        idle(64);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            idle(64);
        end
        rx = 1'b1;
        idle(32);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_data", data, 8'h00);
        chk("mr_valid", valid, 0);
        chk("mr_perr", perr, 0);
        chk("mr_ferr", ferr, 0);
        chk("mr_ovr", ovr, 0);
        chk("mr_busy", busy, 0);
        rst = 1'b0;
        idle(128);
        send(8'hC3, 8, 0, 0, 1, -1, 0, cn);
        chk("c3_data", data, 8'hC3);
        chk("c3_valid", valid, 1);
        chk("c3_ferr", ferr, 0);

        send(8'h1F, 5, 0, 0, 1, -1, 1, cn);
        chk("b5_data", data5, 8'h1F);
        chk("b5_valid", valid5, 1);
        chk("b5_ferr", ferr5, 0);
        pulse_rd();
        pen = 1'b1;
        send(8'h0B, 5, 1, 0, 1, -1, 1, cn);
        chk("b5p_data", data5, 8'h0B);
        chk("b5p_perr", perr5, 1);
        pen = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
